branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch prediction unit for the IF stage of the pipelined core. Today the PC mux resolves every branch, call and ret in EX and flushes IF/ID and ID/EX when one is taken. This block predicts the next PC in the same cycle the PC is presented, using a direct-mapped branch target buffer with 2-bit saturating counters. It is trained by EX-stage resolution, so correctly predicted control flow costs no flush.

## Interface
- ADDR_W, 16, PC and target width
- ENTRIES, 16, BTB entry count; power of two, ≥2; IDX_W = log2(ENTRIES)
- RAS_DEPTH, 4, return-address stack depth; power of two; used only with BP_RAS_EN
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- lu_pc  in  ADDR_W  IF-stage PC to predict
- lu_hit  out  1  valid BTB entry with matching tag
- lu_taken  out  1  predict redirect
- lu_target  out  ADDR_W  predicted next PC; lu_pc+1 when lu_taken=0
- upd_valid  in  1  EX resolved a control instruction this cycle
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_kind  in  2  00 branch, 01 call, 10 ret, 11 reserved (ignored)
- upd_taken  in  1  actual direction (call/ret always 1)
- upd_target  in  ADDR_W  actual target
- upd_mispredict  out  1  registered; prediction made for upd_pc differed from actual

## Operation
- Index = pc[IDX_W-1:0]; tag = pc[ADDR_W-1:IDX_W]. Entry = {valid, tag, kind, ctr[1:0], target}.
- Lookup is combinational from registered table state.
  - Hit: lu_taken = ctr[1] for branch, 1 for call/ret.
  - Miss: lu_taken = 0, lu_target = lu_pc+1 (mod 2^ADDR_W).
- Update when upd_valid and upd_kind≠11:
  - Hit, branch: ctr increments on taken and decrements on not-taken, saturating at 00/11. Target overwritten only when taken.
  - Hit, call/ret: target overwritten.
  - Miss, taken: allocate the entry (overwrites any conflicting tag); ctr=10, kind and target stored.
  - Miss, not-taken branch: no allocation.
- Mispredict compares the update against a lookup of upd_pc on pre-update state. Mispredict = direction mismatch, or taken with target mismatch. Result is registered into upd_mispredict.
- upd_valid=0: no state change; upd_mispredict←0.
- Reset, mid-operation included: all valid←0, all ctr←01, RAS emptied. Outputs go to lu_hit=0, lu_taken=0, lu_target=lu_pc+1, upd_mispredict=0.

## Timing
- Lookup latency 0 cycles (combinational on lu_pc).
- Update latency 1 cycle: visible to lookups from the cycle after the upd_valid edge.
- Same-index lookup and update in one cycle: lookup sees old contents.
- upd_mispredict is valid the cycle after the corresponding upd_valid.
- upd_kind=11 is a no-op and gives upd_mispredict=0.
- No handshake. Callers gate with upd_valid; stalls are handled by the caller holding lu_pc.

## Configuration
- BP_RAS_EN defined:
  - Adds a RAS_DEPTH circular return-address stack with a count.
  - Update of kind call pushes upd_pc+1. When full, the push overwrites the oldest entry and count stays at RAS_DEPTH.
  - Update of kind ret pops. On empty, the pop is a no-op and count stays 0.
  - Hit with kind ret: lu_target = stack top when count>0, else the stored BTB target.
  - Mispredict for ret compares against that same predicted value.
- BP_RAS_EN undefined: no stack. Ret is predicted with the stored BTB target, and a call update has no side effect beyond the BTB.

## Structure
- Shared package: kind encodings (BP_BRANCH, BP_CALL, BP_RET), counter constants (CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11), and the entry struct/field widths.
- One sub-module: bp_ras (the return-address stack), instantiated only under BP_RAS_EN.
- The BTB table, counter update and mispredict logic stay in branch_predictor.

## Test plan
- Reset, then lookup lu_pc=0x0010 -> lu_hit=0, lu_taken=0, lu_target=0x0011; upd_mispredict=0.
- Training: upd branch pc=0x0024 taken target=0x0040 -> next-cycle lookup 0x0024 gives hit, taken, 0x0040, ctr=10. Two not-taken updates -> lu_taken=0 (ctr=00). A further not-taken keeps ctr at 00. Four taken updates saturate ctr at 11.
- Aliasing (ENTRIES=16): 0x0024 and 0x0034 share index 4. A taken update of 0x0034 evicts 0x0024; lookup 0x0024 then misses.
- Mispredict: entry 0x0024 predicted taken→0x0040; upd taken target=0x0050 -> upd_mispredict=1 one cycle later. A same-cycle lookup of 0x0024 still returns 0x0040.
- RAS (BP_RAS_EN, DEPTH=4): five calls at 0x0100..0x0104 then ret entries -> predicted targets 0x0105, 0x0104, 0x0103, 0x0102, then the BTB fallback. Without the macro, ret predicts the last stored target.
- Reset asserted mid-run with trained entries -> all lookups miss immediately; after release, upd_mispredict=0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the IF-stage branch predictor: control-flow kind
// encodings, 2-bit saturating counter constants, the per-entry metadata
// struct and the counter update helper.
// Imported by branch_predictor and bp_ras.
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    // Kind of control instruction, as reported by EX on the update port.
    typedef enum logic [1:0] {
        BP_BRANCH = 2'b00,
        BP_CALL   = 2'b01,
        BP_RET    = 2'b10,
        BP_RSVD   = 2'b11
    } bp_kind_e;

    localparam int KIND_W = 2;
    localparam int CTR_W  = 2;

    // Saturating direction counter states; bit 1 is the predicted direction.
    localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
    localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
    localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

    // Width-independent part of a BTB entry. Tag and target widths depend on
    // the instance parameters, so they live in separate arrays in the top.
    typedef struct packed {
        logic                valid;
        bp_kind_e            kind;
        logic [CTR_W-1:0]    ctr;
    } bp_meta_t;

    // Next counter value, saturating at both ends.
    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                  input logic             taken);
        logic [CTR_W-1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// ---------------------------------------------------------------------------
// bp_ras
// Circular return-address stack used by branch_predictor when BP_RAS_EN is
// defined. A push onto a full stack overwrites the oldest slot and keeps the
// count saturated at DEPTH; a pop of an empty stack does nothing.
//
// Ports:
//   clk        in   clock, state updates on posedge
//   rst_n      in   asynchronous active-low reset (empties the stack)
//   push       in   push push_addr this cycle
//   pop        in   pop the top entry this cycle (ignored when push is set)
//   push_addr  in   return address to push
//   top        out  current top of stack (meaningful only when nonempty)
//   nonempty   out  stack holds at least one entry
// ---------------------------------------------------------------------------
module bp_ras
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top,
    output logic              nonempty
);

    // DEPTH is a power of two >= 2, so the pointer wraps naturally.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  top_idx;

    // ptr_q is the next slot to write; the top sits one below it.
    assign top_idx  = ptr_q - 1'b1;
    assign top      = mem_q[top_idx];
    assign nonempty = (cnt_q != '0);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && nonempty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= push_addr;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// IF-stage next-PC predictor: a direct-mapped BTB with 2-bit saturating
// direction counters, trained by EX-stage resolution. Lookup is purely
// combinational from the registered table; updates land on the next clock.
//
// Optional feature macro: BP_RAS_EN adds a return-address stack (bp_ras)
// that supplies the target for hits of kind ret.
//
// Ports:
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   lu_pc           in   PC to predict
//   lu_hit          out  valid entry with matching tag
//   lu_taken        out  predict a redirect
//   lu_target       out  predicted next PC (lu_pc+1 when not taken)
//   upd_valid       in   EX resolved a control instruction
//   upd_pc          in   PC of that instruction
//   upd_kind        in   00 branch, 01 call, 10 ret, 11 ignored
//   upd_taken       in   actual direction
//   upd_target      in   actual target
//   upd_mispredict  out  registered: prediction for upd_pc was wrong
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lu_pc,
    output logic              lu_hit,
    output logic              lu_taken,
    output logic [ADDR_W-1:0] lu_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [1:0]        upd_kind,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic              upd_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    // Elaboration guard: an illegal geometry leaves this block empty-bodied
    // but makes the mistake easy to spot when reading the hierarchy.
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 ||
        RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
    end

    typedef struct packed {
        logic              hit;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } pred_t;

    bp_meta_t          meta_q [ENTRIES];
    bp_meta_t          meta_d [ENTRIES];
    logic [TAG_W-1:0]  tag_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_d  [ENTRIES];
    logic [ADDR_W-1:0] tgt_q  [ENTRIES];
    logic [ADDR_W-1:0] tgt_d  [ENTRIES];
    logic              upd_mispredict_q, upd_mispredict_d;

    logic [ADDR_W-1:0] ras_top;
    logic              ras_nonempty;
    logic              ras_push, ras_pop;

    logic [IDX_W-1:0]  lu_idx, upd_idx;
    pred_t             lu_pred, upd_pred;
    logic              act_taken;

    // Shared lookup: the same prediction is used for IF and for judging the
    // EX update, so a ret mispredict is measured against the stack value.
    function automatic pred_t predict(input logic [ADDR_W-1:0] pc,
                                      input bp_meta_t          m,
                                      input logic [TAG_W-1:0]  tag,
                                      input logic [ADDR_W-1:0] tgt,
                                      input logic [ADDR_W-1:0] stk_top,
                                      input logic              stk_ok);
        pred_t p;
        p.hit    = m.valid && (tag == pc[ADDR_W-1:IDX_W]);
        p.taken  = 1'b0;
        p.target = pc + ADDR_W'(1);
        if (p.hit) begin
            case (m.kind)
                BP_BRANCH: p.taken = m.ctr[1];
                BP_CALL:   p.taken = 1'b1;
                BP_RET:    p.taken = 1'b1;
                default:   p.taken = 1'b0;
            endcase
            if (p.taken) begin
                p.target = (m.kind == BP_RET && stk_ok) ? stk_top : tgt;
            end
        end
        return p;
    endfunction

    assign lu_idx  = lu_pc[IDX_W-1:0];
    assign upd_idx = upd_pc[IDX_W-1:0];

    assign lu_pred  = predict(lu_pc, meta_q[lu_idx], tag_q[lu_idx], tgt_q[lu_idx],
                              ras_top, ras_nonempty);
    assign upd_pred = predict(upd_pc, meta_q[upd_idx], tag_q[upd_idx], tgt_q[upd_idx],
                              ras_top, ras_nonempty);

    assign lu_hit         = lu_pred.hit;
    assign lu_taken       = lu_pred.taken;
    assign lu_target      = lu_pred.target;
    assign upd_mispredict = upd_mispredict_q;

    // Calls and rets always redirect regardless of what EX reports.
    assign act_taken = (upd_kind == BP_BRANCH) ? upd_taken : 1'b1;

    assign ras_push = upd_valid && (upd_kind == BP_CALL);
    assign ras_pop  = upd_valid && (upd_kind == BP_RET);

    // Table training and mispredict detection, all against pre-update state.
    always_comb begin
        meta_d           = meta_q;
        tag_d            = tag_q;
        tgt_d            = tgt_q;
        upd_mispredict_d = 1'b0;
        if (upd_valid && upd_kind != BP_RSVD) begin
            upd_mispredict_d = (upd_pred.taken != act_taken) ||
                               (act_taken && upd_pred.target != upd_target);
            if (upd_pred.hit) begin
                meta_d[upd_idx].kind = bp_kind_e'(upd_kind);
                if (upd_kind == BP_BRANCH) begin
                    meta_d[upd_idx].ctr = ctr_next(meta_q[upd_idx].ctr, upd_taken);
                    if (upd_taken) begin
                        tgt_d[upd_idx] = upd_target;
                    end
                end else begin
                    tgt_d[upd_idx] = upd_target;
                end
            end else if (act_taken) begin
                // Allocation evicts whatever aliased into this slot.
                meta_d[upd_idx].valid = 1'b1;
                meta_d[upd_idx].kind  = bp_kind_e'(upd_kind);
                meta_d[upd_idx].ctr   = CTR_WT;
                tag_d[upd_idx]        = upd_pc[ADDR_W-1:IDX_W];
                tgt_d[upd_idx]        = upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i] <= '{valid: 1'b0, kind: BP_BRANCH, ctr: CTR_WNT};
                tag_q[i]  <= '0;
                tgt_q[i]  <= '0;
            end
            upd_mispredict_q <= 1'b0;
        end else begin
            meta_q           <= meta_d;
            tag_q            <= tag_d;
            tgt_q            <= tgt_d;
            upd_mispredict_q <= upd_mispredict_d;
        end
    end

`ifdef BP_RAS_EN
    bp_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (upd_pc + ADDR_W'(1)),
        .top       (ras_top),
        .nonempty  (ras_nonempty)
    );
`else
    // Without a stack, ret falls back to the stored BTB target.
    logic ras_unused;
    assign ras_unused   = ras_push ^ ras_pop;
    assign ras_top      = {ADDR_W{ras_unused & 1'b0}};
    assign ras_nonempty = 1'b0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ADDR_W=16, ENTRIES=16, RAS_DEPTH=4).
// Stimulus pushes expected values into a scoreboard queue tagged with the
// cycle in which they are due; a monitor pops and compares them on negedge.
module tb_branch_predictor;

   localparam logic [1:0] K_BR   = 2'b00;
   localparam logic [1:0] K_CALL = 2'b01;
   localparam logic [1:0] K_RET  = 2'b10;
   localparam logic [1:0] K_RSVD = 2'b11;

   localparam int F_HIT  = 0;
   localparam int F_TKN  = 1;
   localparam int F_TGT  = 2;
   localparam int F_MISP = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] lu_pc = '0;
   logic        lu_hit;
   logic        lu_taken;
   logic [15:0] lu_target;
   logic        upd_valid = 1'b0;
   logic [15:0] upd_pc = '0;
   logic [1:0]  upd_kind = '0;
   logic        upd_taken = 1'b0;
   logic [15:0] upd_target = '0;
   logic        upd_mispredict;

   typedef struct {
      string       name;
      int          due;
      int          field;
      logic [15:0] exp;
   } chk_t;

   chk_t sb[$];
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   branch_predictor #(
      .ADDR_W    (16),
      .ENTRIES   (16),
      .RAS_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lu_pc          (lu_pc),
      .lu_hit         (lu_hit),
      .lu_taken       (lu_taken),
      .lu_target      (lu_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_kind       (upd_kind),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_mispredict (upd_mispredict)
   );

   always #5 clk = ~clk;

   // Cycle counter used to tag when each expectation becomes due.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every scoreboard entry that is due this cycle.
   always @(negedge clk) begin : monitor
      chk_t        c;
      logic [15:0] act;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         c = sb.pop_front();
         case (c.field)
            F_HIT:   act = {15'b0, lu_hit};
            F_TKN:   act = {15'b0, lu_taken};
            F_TGT:   act = lu_target;
            default: act = {15'b0, upd_mispredict};
         endcase
         tests_run++;
         if (c.due != cyc || act !== c.exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h (due %0d, cycle %0d)",
                     c.name, act, c.exp, c.due, cyc);
         end
      end
   end

   // Drive one cycle's inputs just after the rising edge.
   task automatic applyStimulus(input logic [15:0] lpc, input logic uv,
                                input logic [1:0] kind, input logic [15:0] upc,
                                input logic ut, input logic [15:0] utgt);
      @(posedge clk);
      #1;
      lu_pc      = lpc;
      upd_valid  = uv;
      upd_kind   = kind;
      upd_pc     = upc;
      upd_taken  = ut;
      upd_target = utgt;
   endtask

   // Queue an expectation due `delay` cycles from the current one.
   task automatic checkOutput(input string nm, input int field,
                              input logic [15:0] exp, input int delay);
      chk_t c;
      c.name  = nm;
      c.due   = cyc + delay;
      c.field = field;
      c.exp   = exp;
      sb.push_back(c);
   endtask

   task automatic expectLookup(input string nm, input logic hit,
                               input logic tkn, input logic [15:0] tgt);
      checkOutput({nm, "_hit"}, F_HIT, {15'b0, hit}, 0);
      checkOutput({nm, "_taken"}, F_TKN, {15'b0, tkn}, 0);
      checkOutput({nm, "_target"}, F_TGT, tgt, 0);
   endtask

   // One cycle: drive lookup and update, expect lookup now, mispredict next.
   task automatic runStep(input string nm, input logic [15:0] lpc,
                          input logic uv, input logic [1:0] kind,
                          input logic [15:0] upc, input logic ut,
                          input logic [15:0] utgt, input logic ehit,
                          input logic etkn, input logic [15:0] etgt,
                          input logic emisp);
      applyStimulus(lpc, uv, kind, upc, ut, utgt);
      expectLookup(nm, ehit, etkn, etgt);
      checkOutput({nm, "_misp"}, F_MISP, {15'b0, emisp}, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stim
      int guard;
      // Reset state
      applyStimulus(16'h0010, 1'b0, K_BR, 16'h0000, 1'b0, 16'h0000);
      expectLookup("rst", 1'b0, 1'b0, 16'h0011);
      checkOutput("rst_misp", F_MISP, 16'h0000, 0);
      applyStimulus(16'h0010, 1'b0, K_BR, 16'h0000, 1'b0, 16'h0000);
      rst_n = 1'b1;
      expectLookup("rel", 1'b0, 1'b0, 16'h0011);
      checkOutput("rel_misp", F_MISP, 16'h0000, 1);

      // Training and counter saturation on 0x0024
      runStep("train0", 16'h0024, 1, K_BR, 16'h0024, 1, 16'h0040, 0, 0, 16'h0025, 1);
      runStep("train1", 16'h0024, 0, K_BR, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 0);
      runStep("nt1",    16'h0024, 1, K_BR, 16'h0024, 0, 16'h0000, 1, 1, 16'h0040, 1);
      runStep("nt2",    16'h0024, 1, K_BR, 16'h0024, 0, 16'h0000, 1, 0, 16'h0025, 0);
      runStep("nt3",    16'h0024, 1, K_BR, 16'h0024, 0, 16'h0000, 1, 0, 16'h0025, 0);
      runStep("tk1",    16'h0024, 1, K_BR, 16'h0024, 1, 16'h0040, 1, 0, 16'h0025, 1);
      runStep("tk2",    16'h0024, 1, K_BR, 16'h0024, 1, 16'h0040, 1, 0, 16'h0025, 1);
      runStep("tk3",    16'h0024, 1, K_BR, 16'h0024, 1, 16'h0040, 1, 1, 16'h0040, 0);
      runStep("tk4",    16'h0024, 1, K_BR, 16'h0024, 1, 16'h0040, 1, 1, 16'h0040, 0);
      runStep("ntsat",  16'h0024, 1, K_BR, 16'h0024, 0, 16'h0000, 1, 1, 16'h0040, 1);
      runStep("ctr10",  16'h0024, 0, K_BR, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 0);

      // Target mispredict, same-cycle lookup sees the old target
      runStep("tgtmis", 16'h0024, 1, K_BR, 16'h0024, 1, 16'h0050, 1, 1, 16'h0040, 1);
      runStep("tgtnew", 16'h0024, 0, K_BR, 16'h0000, 0, 16'h0000, 1, 1, 16'h0050, 0);

      // Aliasing: 0x0034 evicts 0x0024 (index 4)
      runStep("alias",  16'h0034, 1, K_BR, 16'h0034, 1, 16'h0060, 0, 0, 16'h0035, 1);
      runStep("evict",  16'h0024, 0, K_BR, 16'h0000, 0, 16'h0000, 0, 0, 16'h0025, 0);
      runStep("alias2", 16'h0034, 0, K_BR, 16'h0000, 0, 16'h0000, 1, 1, 16'h0060, 0);

      // Call / ret / reserved
      runStep("call",    16'h0100, 1, K_CALL, 16'h0100, 1, 16'h0300, 0, 0, 16'h0101, 1);
      runStep("callhit", 16'h0100, 0, K_BR,   16'h0000, 0, 16'h0000, 1, 1, 16'h0300, 0);
      runStep("ret",     16'h0209, 1, K_RET,  16'h0209, 1, 16'h0777, 0, 0, 16'h020A, 1);
      runStep("rethit",  16'h0209, 0, K_BR,   16'h0000, 0, 16'h0000, 1, 1, 16'h0777, 0);
      runStep("rsvd",    16'h0300, 1, K_RSVD, 16'h0300, 1, 16'h0010, 0, 0, 16'h0301, 0);
      runStep("rsvd2",   16'h0300, 0, K_BR,   16'h0000, 0, 16'h0000, 0, 0, 16'h0301, 0);

`ifdef BP_RAS_EN
      // Five calls overflow the 4-deep stack: holds 0x0102..0x0105
      runStep("c0", 16'h0100, 1, K_CALL, 16'h0100, 1, 16'h0300, 1, 1, 16'h0300, 0);
      runStep("c1", 16'h0101, 1, K_CALL, 16'h0101, 1, 16'h0300, 0, 0, 16'h0102, 1);
      runStep("c2", 16'h0102, 1, K_CALL, 16'h0102, 1, 16'h0300, 0, 0, 16'h0103, 1);
      runStep("c3", 16'h0103, 1, K_CALL, 16'h0103, 1, 16'h0300, 0, 0, 16'h0104, 1);
      runStep("c4", 16'h0104, 1, K_CALL, 16'h0104, 1, 16'h0300, 0, 0, 16'h0105, 1);
      runStep("r0", 16'h0209, 1, K_RET, 16'h0209, 1, 16'h0105, 1, 1, 16'h0105, 0);
      runStep("r1", 16'h0209, 1, K_RET, 16'h0209, 1, 16'h0104, 1, 1, 16'h0104, 0);
      runStep("r2", 16'h0209, 1, K_RET, 16'h0209, 1, 16'h0103, 1, 1, 16'h0103, 0);
      runStep("r3", 16'h0209, 1, K_RET, 16'h0209, 1, 16'h0888, 1, 1, 16'h0102, 1);
      runStep("rfall",  16'h0209, 0, K_BR,  16'h0000, 0, 16'h0000, 1, 1, 16'h0888, 0);
      runStep("rempty", 16'h0209, 1, K_RET, 16'h0209, 1, 16'h0888, 1, 1, 16'h0888, 0);
      runStep("rfall2", 16'h0209, 0, K_BR,  16'h0000, 0, 16'h0000, 1, 1, 16'h0888, 0);
`else
      runStep("retbtb",  16'h0209, 1, K_RET, 16'h0209, 1, 16'h0999, 1, 1, 16'h0777, 1);
      runStep("retbtb2", 16'h0209, 0, K_BR,  16'h0000, 0, 16'h0000, 1, 1, 16'h0999, 0);
`endif

      // Mid-run reset: a pending mispredict and trained entries are cleared
      runStep("prerst", 16'h0034, 1, K_BR, 16'h0034, 0, 16'h0000, 1, 1, 16'h0060, 0);
      applyStimulus(16'h0209, 1'b0, K_BR, 16'h0000, 1'b0, 16'h0000);
      rst_n = 1'b0;
      expectLookup("midrst", 1'b0, 1'b0, 16'h020A);
      runStep("inrst", 16'h0034, 0, K_BR, 16'h0000, 0, 16'h0000, 0, 0, 16'h0035, 0);
      rst_n = 1'b1;
      runStep("post1", 16'h0024, 1, K_BR, 16'h0024, 0, 16'h0000, 0, 0, 16'h0025, 0);
      runStep("post2", 16'h0024, 0, K_BR, 16'h0000, 0, 16'h0000, 0, 0, 16'h0025, 0);

      // Drain the scoreboard with a bounded wait
      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      @(posedge clk);
      if (sb.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL drain: got %0d pending checks expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
